// File: rtl/spi_master_cfg.sv
// Parametrised full-duplex SPI master: configurable word width, CPOL/CPHA,
// SCLK divider, bit order and one-hot-decoded chip selects.
//
// state | meaning
// IDLE  | waiting for start, sclk parked at last cpol, cs_n all high
// SETUP | chip select asserted, first bit presented when cpha = 0
// XFER  | 2*DATA_W SCLK half-periods, shifting mosi and sampling miso
// HOLD  | sclk back at cpol, chip select still asserted
// DONE  | one-cycle completion pulse, dout valid
module spi_master_cfg #(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 4,
    parameter int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              msb_first,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic              miso,
    output logic              sclk,
    output logic              mosi,
    output logic [NUM_CS-1:0] cs_n,
    output logic [DATA_W-1:0] dout,
    output logic              busy,
    output logic              done
);

    localparam int HC_W = $clog2(2 * DATA_W);
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(2 * DATA_W - 1);
    localparam logic [HC_W-1:0] HC_PEN  = HC_W'(2 * DATA_W - 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_XFER,
        S_HOLD,
        S_DONE
    } state_t;

    state_t state;
    state_t state_nxt;

    logic              rst_q;
    logic [DIV_W-1:0]  div_cnt;
    logic [DIV_W-1:0]  div_q;
    logic [HC_W-1:0]   half_cnt;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic [CS_W-1:0]   cs_q;
    logic              cpol_q;
    logic              cpha_q;
    logic              msb_q;

    logic accept;
    logic tc;
    logic edge_ev;
    logic leading;
    logic last_edge;
    logic sample_ev;
    logic drive_ev;
    logic tx_bit;
    logic first_bit;

    // Reset release is retimed by one flop so the first start lands on the
    // second clk edge after rst rises.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_q <= 1'b0;
        end else begin
            rst_q <= 1'b1;
        end
    end

    assign accept    = (state == S_IDLE) && start && rst_q;
    assign tc        = (div_cnt == '0);
    // SCLK edges fall on entry to each XFER half-period.
    assign edge_ev   = tc && ((state == S_SETUP) ||
                              ((state == S_XFER) && (half_cnt != HC_LAST)));
    assign leading   = edge_ev && (sclk == cpol_q);
    assign last_edge = (state == S_XFER) && (half_cnt == HC_PEN);
    assign sample_ev = edge_ev && (cpha_q ? !leading : leading);
    assign drive_ev  = edge_ev && (cpha_q ? leading : (!leading && !last_edge));
    assign tx_bit    = msb_q ? tx_sr[DATA_W-1] : tx_sr[0];
    assign first_bit = msb_first ? din[DATA_W-1] : din[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_SETUP;
            S_SETUP: if (tc) state_nxt = S_XFER;
            S_XFER:  if (tc && (half_cnt == HC_LAST)) state_nxt = S_HOLD;
            S_HOLD:  if (tc) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_SETUP) || (state == S_XFER) || (state == S_HOLD);
        done = (state == S_DONE);
        cs_n = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (busy && (int'(cs_q) == i)) begin
                cs_n[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt  <= '0;
            div_q    <= '0;
            half_cnt <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            cs_q     <= '0;
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            msb_q    <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            dout     <= '0;
        end else if (accept) begin
            div_cnt  <= clk_div;
            div_q    <= clk_div;
            half_cnt <= '0;
            cs_q     <= cs_sel;
            cpol_q   <= cpol;
            cpha_q   <= cpha;
            msb_q    <= msb_first;
            sclk     <= cpol;
            rx_sr    <= '0;
            if (cpha) begin
                mosi  <= 1'b0;
                tx_sr <= din;
            end else begin
                mosi  <= first_bit;
                tx_sr <= msb_first ? (din << 1) : (din >> 1);
            end
        end else if (busy) begin
            div_cnt <= tc ? div_q : div_cnt - DIV_W'(1);
            if ((state == S_XFER) && tc) begin
                half_cnt <= half_cnt + HC_W'(1);
            end
            if (edge_ev) begin
                sclk <= !sclk;
            end
            if (sample_ev) begin
                rx_sr <= msb_q ? {rx_sr[DATA_W-2:0], miso} : {miso, rx_sr[DATA_W-1:1]};
            end
            if (drive_ev) begin
                mosi  <= tx_bit;
                tx_sr <= msb_q ? (tx_sr << 1) : (tx_sr >> 1);
            end
            if ((state == S_HOLD) && tc) begin
                dout <= rx_sr;
            end
        end else if (state == S_DONE) begin
            mosi <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_master_cfg.sv
// Scoreboard bench for spi_master_cfg: expectations queued at launch,
// checked against bus activity when done pulses.
module tb_spi_master_cfg;

    localparam int DW  = 8;
    localparam int NCS = 4;
    localparam int CSW = 3;
    localparam int DVW = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic [DW-1:0]  din = '0;
    logic [CSW-1:0] cs_sel = '0;
    logic           cpol = 1'b0;
    logic           cpha = 1'b0;
    logic           msb_first = 1'b1;
    logic [DVW-1:0] clk_div = '0;
    logic           miso;
    logic           sclk;
    logic           mosi;
    logic [NCS-1:0] cs_n;
    logic [DW-1:0]  dout;
    logic           busy;
    logic           done;

    logic loop = 1'b1;
    logic miso_s = 1'b0;
    assign miso = loop ? mosi : miso_s;

    spi_master_cfg #(
        .DATA_W (DW),
        .NUM_CS (NCS),
        .CS_W   (CSW),
        .DIV_W  (DVW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .din       (din),
        .cs_sel    (cs_sel),
        .cpol      (cpol),
        .cpha      (cpha),
        .msb_first (msb_first),
        .clk_div   (clk_div),
        .miso      (miso),
        .sclk      (sclk),
        .mosi      (mosi),
        .cs_n      (cs_n),
        .dout      (dout),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] dout;
        logic [3:0] cs;
        int         cslow;
        int         blen;
        logic [7:0] monw;
    } exp_t;

    exp_t sbq[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

    // monitor state
    logic       cur_cpol = 1'b0;
    logic       cur_cpha = 1'b0;
    logic       slave_on = 1'b0;
    logic [7:0] slave_tx = '0;
    int         busy_cnt, cslow_cnt, rises, edges, done_cnt, gap, last_gap;
    logic [3:0] cs_and, cs_or;
    logic [7:0] monw;
    logic       busy_p, sclk_p, lead, samp;
    logic [7:0] dout_p;

    task automatic clr_mon();
        busy_cnt  = 0;
        cslow_cnt = 0;
        rises     = 0;
        edges     = 0;
        cs_and    = 4'hF;
        cs_or     = 4'h0;
        monw      = '0;
    endtask

    initial begin
        clr_mon();
        done_cnt = 0;
        gap      = 0;
        last_gap = 0;
        busy_p   = 1'b0;
        sclk_p   = 1'b0;
        dout_p   = '0;
    end

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            clr_mon();
            gap    = 0;
            busy_p = 1'b0;
            sclk_p = sclk;
            dout_p = dout;
        end else begin
            if (busy) begin
                busy_cnt++;
                cs_and = cs_and & cs_n;
                cs_or  = cs_or | cs_n;
            end
            if (cs_n != 4'hF) cslow_cnt++;
            if (busy && busy_p && (sclk != sclk_p)) begin
                edges++;
                if (sclk) rises++;
                lead = (sclk != cur_cpol);
                samp = cur_cpha ? !lead : lead;
                if (samp) monw = {monw[6:0], mosi};
                if (lead && slave_on) begin
                    miso_s   = slave_tx[7];
                    slave_tx = {slave_tx[6:0], 1'b0};
                end
            end
            if ((dout !== dout_p) && !done) check("dout_stable", dout, dout_p);
            if (cs_n == 4'hF) begin
                gap++;
            end else begin
                if (gap > 0) last_gap = gap;
                gap = 0;
            end
            if (done) begin
                done_cnt++;
                if (sbq.size() > 0) begin
                    e = sbq.pop_front();
                    check("dout", dout, e.dout);
                    check("busy_len", busy_cnt, e.blen);
                    check("cs_low_len", cslow_cnt, e.cslow);
                    check("cs_pat_and", cs_and, e.cs);
                    check("cs_pat_or", cs_or, e.cs);
                    check("sclk_rises", rises, 8);
                    check("mosi_seq", monw, e.monw);
                end
                clr_mon();
            end
            busy_p = busy;
            sclk_p = sclk;
            dout_p = dout;
        end
    end

    task automatic push_exp(input logic [7:0] d, input logic [2:0] sel, input logic msb,
                            input logic [7:0] div, input logic [7:0] expd);
        exp_t       e;
        logic [3:0] one = 4'b0001;
        e.dout  = expd;
        e.blen  = (int'(div) + 1) * 18;
        e.cs    = (sel < 4) ? ~(one << sel) : 4'hF;
        e.cslow = (sel < 4) ? e.blen : 0;
        e.monw  = msb ? d : rev8(d);
        sbq.push_back(e);
    endtask

    task automatic launch(input logic [7:0] d, input logic [2:0] sel, input logic c_pol,
                          input logic c_pha, input logic msb, input logic [7:0] div,
                          input logic [7:0] expd, input bit push);
        @(negedge clk);
        din       = d;
        cs_sel    = sel;
        cpol      = c_pol;
        cpha      = c_pha;
        msb_first = msb;
        clk_div   = div;
        start     = 1'b1;
        cur_cpol  = c_pol;
        cur_cpha  = c_pha;
        if (push) push_exp(d, sel, msb, div, expd);
    endtask

    task automatic release_start();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (((sbq.size() != 0) || busy) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        if ((sbq.size() != 0) || busy) check("timeout_drain", sbq.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_busy(input logic lvl, input int budget);
        int n = 0;
        while ((busy !== lvl) && (n < budget)) begin
            @(negedge clk);
            n++;
        end
        if (busy !== lvl) check("timeout_busy", busy, lvl);
    endtask

    initial begin
        int n;
        // reset values
        repeat (3) @(negedge clk);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_cs_n", cs_n, 4'hF);
        check("rst_dout", dout, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // mode 0 loopback
        loop = 1'b1;
        launch(8'hA5, 3'd2, 1'b0, 1'b0, 1'b1, 8'd0, 8'hA5, 1'b1);
        release_start();
        wait_drain(2000);
        check("done_cnt_t1", done_cnt, 1);
        check("idle_mosi", mosi, 0);

        // mode 3 against slave model
        loop     = 1'b0;
        slave_on = 1'b1;
        slave_tx = 8'h3C;
        launch(8'h81, 3'd0, 1'b1, 1'b1, 1'b1, 8'd3, 8'h3C, 1'b1);
        release_start();
        wait_drain(4000);
        check("sclk_idle_hi", sclk, 1);
        check("done_cnt_t2", done_cnt, 2);
        slave_on = 1'b0;
        loop     = 1'b1;

        // LSB-first, mode 1 loopback
        launch(8'h01, 3'd1, 1'b0, 1'b1, 1'b0, 8'd1, 8'h01, 1'b1);
        release_start();
        wait_drain(2000);
        check("done_cnt_t3", done_cnt, 3);

        // illegal select plus ignored start mid-transfer
        launch(8'h96, 3'd5, 1'b0, 1'b0, 1'b1, 8'd1, 8'h96, 1'b1);
        release_start();
        repeat (10) @(negedge clk);
        din    = 8'hFF;
        cs_sel = 3'd0;
        cpol   = 1'b1;
        start  = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b0;
        wait_drain(2000);
        repeat (5) @(negedge clk);
        check("done_cnt_t4", done_cnt, 4);
        check("ign_cpol_sclk", sclk, 0);
        check("ign_dout", dout, 8'h96);

        // reset at the 5th sclk edge
        launch(8'hC3, 3'd0, 1'b0, 1'b0, 1'b1, 8'd1, 8'h00, 1'b0);
        release_start();
        n = 0;
        while ((edges < 5) && (n < 500)) begin
            @(negedge clk);
            n++;
        end
        check("mid_edges", edges, 5);
        rst = 1'b0;
        #1;
        check("mid_sclk", sclk, 0);
        check("mid_cs_n", cs_n, 4'hF);
        check("mid_busy", busy, 0);
        check("mid_done", done, 0);
        repeat (3) @(negedge clk);
        check("mid_no_done", done_cnt, 4);
        check("mid_dout", dout, 0);

        // reset release timing, then 0x5A loopback
        launch(8'h5A, 3'd3, 1'b0, 1'b0, 1'b1, 8'd0, 8'h5A, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("sync_edge1_busy", busy, 0);
        @(posedge clk);
        #1;
        check("sync_edge2_busy", busy, 1);
        release_start();
        wait_drain(2000);
        check("done_cnt_t5", done_cnt, 5);

        // back-to-back with start held
        launch(8'h12, 3'd1, 1'b0, 1'b0, 1'b1, 8'd0, 8'h12, 1'b1);
        wait_busy(1'b1, 50);
        din = 8'h34;
        push_exp(8'h34, 3'd1, 1'b1, 8'd0, 8'h34);
        wait_busy(1'b0, 100);
        wait_busy(1'b1, 50);
        start = 1'b0;
        wait_drain(2000);
        check("b2b_done_cnt", done_cnt, 7);
        check("b2b_cs_gap", last_gap, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "global timeout");
    end

endmodule
